vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; the successor to the standalone vertical sync block.
- Generates hsync, vsync, display enable and pixel coordinates from one horizontal counter and one vertical counter.
- Horizontal and vertical timings and sync polarities are set by parameters.
- A pixel-rate enable lets it run from a faster system clock. It sits between the clock source and the pixel/framebuffer logic.

Parameters:
- H_SYNCPULSE, 96, hsync pulse width in pixel ticks
- H_BPORCH, 48, horizontal back porch ticks
- H_DISPLAY, 640, visible pixels per line
- H_FPORCH, 16, horizontal front porch ticks
- V_SYNCPULSE, 2, vsync pulse width in lines
- V_BPORCH, 33, vertical back porch lines
- V_DISPLAY, 480, visible lines per frame
- V_FPORCH, 10, vertical front porch lines
- H_SYNC_POL, 0, active level of hsync (0 = active low)
- V_SYNC_POL, 0, active level of vsync
- X_W, 10, width of x / hcount; must hold H_TOTAL-1
- Y_W, 10, width of y / vcount; must hold V_TOTAL-1
- Derived: H_TOTAL = sum of the four H_* timing values (800); V_TOTAL = sum of the four V_* timing values (525)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  pixel tick enable; the block advances only on cycles with en=1
- hsync  out  1  horizontal sync at the H_SYNC_POL level while active
- vsync  out  1  vertical sync at the V_SYNC_POL level while active
- display_en  out  1  high while the presented position is inside the visible window
- x  out  X_W  visible pixel column, 0..H_DISPLAY-1; 0 outside the visible window
- y  out  Y_W  visible line, 0..V_DISPLAY-1; 0 outside the visible window
- hcount  out  X_W  raw horizontal position presented, 0..H_TOTAL-1
- vcount  out  Y_W  raw vertical position presented, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when hcount==0 is presented
- frame_start  out  1  one-clk pulse when hcount==0 and vcount==0 are presented

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high and has priority over en.
- Internal counters h_nxt, v_nxt hold the next position to present. Reset sets both to 0.
- Reset values of outputs:
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
  - display_en = 0, x = y = hcount = vcount = 0
  - line_start = frame_start = 0
- On a clk edge with en=1 and reset=0:
  - all outputs register the decode of (h_nxt, v_nxt); latency is 1 clk from the counter to the outputs
  - h_nxt increments. At H_TOTAL-1 it wraps to 0 and v_nxt advances; v_nxt wraps from V_TOTAL-1 to 0.
- Line layout (sync pulse first):
  - [0, H_SYNCPULSE) = sync
  - then back porch
  - [HS0, HS0+H_DISPLAY) = visible, with HS0 = H_SYNCPULSE + H_BPORCH
  - then front porch
  - vertical layout is identical using the V_* values; VS0 = V_SYNCPULSE + V_BPORCH
- Decode rules:
  - hsync is active iff h < H_SYNCPULSE; vsync is active iff v < V_SYNCPULSE. Vsync spans whole lines, edges aligned to h=0.
  - display_en = (HS0 <= h < HS0+H_DISPLAY) AND (VS0 <= v < VS0+V_DISPLAY)
  - x = h-HS0 and y = v-VS0 when display_en=1, else 0
- en=1 with reset=0: line_start = (h==0), frame_start = (h==0 && v==0); each pulse lasts exactly one clk.
- en=0 cycles:
  - counters and level outputs (hsync, vsync, display_en, x, y, hcount, vcount) hold
  - line_start and frame_start are forced to 0
- Reset mid-frame: outputs return to reset values on the next edge. The first en tick after reset is released presents (0,0), with hsync, vsync, line_start and frame_start all active.
- Arithmetic: counters are unsigned, X_W/Y_W bits; no overflow is possible given valid widths. Subtraction for x and y is done only inside the visible window.
- All H_* and V_* parameters must be >= 1. Behaviour with H_TOTAL or V_TOTAL exceeding 2^X_W or 2^Y_W is undefined.

Test Plan:
- Reset held for 5 clks with en=1: hsync=1, vsync=1, display_en=0, all counters 0. First en after release: hcount=0, vcount=0, hsync=0, vsync=0, frame_start=1, line_start=1.
- Defaults, en=1 constant:
  - hsync low for exactly 96 clks per line; line_start period is 800 clks
  - vsync low for exactly 1600 clks; frame_start period is 420000 clks
- Defaults, visible window:
  - display_en first rises at hcount=144, vcount=35, with x=0, y=0
  - last visible pixel is hcount=783, vcount=514, with x=639, y=479
  - total display_en count per frame = 307200
- en driven 1-in-4:
  - all periods scale ×4 in clks
  - line_start and frame_start stay 1 clk wide
  - levels hold between ticks
- Small params H=2/1/4/1 (H_TOTAL=8), V=1/1/3/1 (V_TOTAL=6), H_SYNC_POL=V_SYNC_POL=1:
  - full 48-tick frame matches a reference model cycle-by-cycle
  - hsync is high at hcount 0..1; x = 0..3 at hcount 3..6
- reset asserted at hcount=500, vcount=200: the next clk shows reset values, and the first en tick after release shows (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// One horizontal and one vertical counter hold the next raster position to
// present. On every pixel tick (en=1) the outputs register the decode of that
// position and the counters advance, so outputs lag the counters by one clk.
// Each line and each frame is laid out as sync, back porch, visible, front porch.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset, priority over en
//   en          in   pixel tick enable
//   hsync       out  horizontal sync, H_SYNC_POL level while active
//   vsync       out  vertical sync, V_SYNC_POL level while active
//   display_en  out  presented position is inside the visible window
//   x, y        out  visible column / line, 0 outside the window
//   hcount      out  raw horizontal position presented
//   vcount      out  raw vertical position presented
//   line_start  out  one-clk pulse when hcount==0 is presented
//   frame_start out  one-clk pulse when hcount==0 and vcount==0 are presented
module vga_timing_gen #(
  parameter int H_SYNCPULSE = 96,
  parameter int H_BPORCH    = 48,
  parameter int H_DISPLAY   = 640,
  parameter int H_FPORCH    = 16,
  parameter int V_SYNCPULSE = 2,
  parameter int V_BPORCH    = 33,
  parameter int V_DISPLAY   = 480,
  parameter int V_FPORCH    = 10,
  parameter int H_SYNC_POL  = 0,
  parameter int V_SYNC_POL  = 0,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           display_en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] hcount,
  output logic [Y_W-1:0] vcount,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = H_SYNCPULSE + H_BPORCH + H_DISPLAY + H_FPORCH;
  localparam int V_TOTAL = V_SYNCPULSE + V_BPORCH + V_DISPLAY + V_FPORCH;
  localparam int HS0     = H_SYNCPULSE + H_BPORCH;
  localparam int VS0     = V_SYNCPULSE + V_BPORCH;

  // Boundaries pre-sized to the counter widths; the front porch is at least
  // one tick, so the visible end always fits below the total.
  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_SYNCPULSE);
  localparam logic [X_W-1:0] H_VIS_BEG  = X_W'(HS0);
  localparam logic [X_W-1:0] H_VIS_END  = X_W'(HS0 + H_DISPLAY);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_SYNCPULSE);
  localparam logic [Y_W-1:0] V_VIS_BEG  = Y_W'(VS0);
  localparam logic [Y_W-1:0] V_VIS_END  = Y_W'(VS0 + V_DISPLAY);
  localparam logic           H_ACT      = 1'(H_SYNC_POL);
  localparam logic           V_ACT      = 1'(V_SYNC_POL);

  logic [X_W-1:0] h_nxt_q, h_nxt_d;
  logic [Y_W-1:0] v_nxt_q, v_nxt_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] hcount_q, hcount_d;
  logic [Y_W-1:0] vcount_q, vcount_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;

  logic h_vis_s;
  logic v_vis_s;

  assign h_vis_s = (h_nxt_q >= H_VIS_BEG) && (h_nxt_q < H_VIS_END);
  assign v_vis_s = (v_nxt_q >= V_VIS_BEG) && (v_nxt_q < V_VIS_END);

  // Next-state: decode the pending position and advance on a pixel tick;
  // otherwise hold levels and drop the start pulses.
  always_comb begin
    h_nxt_d  = h_nxt_q;
    v_nxt_d  = v_nxt_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    x_d      = x_q;
    y_d      = y_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    ls_d     = 1'b0;
    fs_d     = 1'b0;
    if (en) begin
      hsync_d  = (h_nxt_q < H_SYNC_END) ? H_ACT : ~H_ACT;
      vsync_d  = (v_nxt_q < V_SYNC_END) ? V_ACT : ~V_ACT;
      de_d     = h_vis_s && v_vis_s;
      // Offsets are only formed inside the window so they never wrap.
      x_d      = (h_vis_s && v_vis_s) ? (h_nxt_q - H_VIS_BEG) : {X_W{1'b0}};
      y_d      = (h_vis_s && v_vis_s) ? (v_nxt_q - V_VIS_BEG) : {Y_W{1'b0}};
      hcount_d = h_nxt_q;
      vcount_d = v_nxt_q;
      ls_d     = (h_nxt_q == {X_W{1'b0}});
      fs_d     = (h_nxt_q == {X_W{1'b0}}) && (v_nxt_q == {Y_W{1'b0}});
      if (h_nxt_q == H_LAST) begin
        h_nxt_d = {X_W{1'b0}};
        if (v_nxt_q == V_LAST) begin
          v_nxt_d = {Y_W{1'b0}};
        end else begin
          v_nxt_d = v_nxt_q + {{(Y_W-1){1'b0}}, 1'b1};
        end
      end else begin
        h_nxt_d = h_nxt_q + {{(X_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ls_d = 1'b0;
      fs_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_nxt_q  <= {X_W{1'b0}};
      v_nxt_q  <= {Y_W{1'b0}};
      hsync_q  <= ~H_ACT;
      vsync_q  <= ~V_ACT;
      de_q     <= 1'b0;
      x_q      <= {X_W{1'b0}};
      y_q      <= {Y_W{1'b0}};
      hcount_q <= {X_W{1'b0}};
      vcount_q <= {Y_W{1'b0}};
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_nxt_q  <= h_nxt_d;
      v_nxt_q  <= v_nxt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_en  = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
